// File: rtl/gray_pkg.sv
// gray_pkg -- shared constants and helpers for the Gray-code blocks
// (gray_counter, binary_to_gray, and the downstream gray_to_binary).
//   GRAY_WIDTH_DEF : default code width
//   bin2gray       : binary -> reflected Gray (up to 32 bits, zero-extended)
//   gray2bin       : reflected Gray -> binary (up to 32 bits, zero-extended)
//   is_one_hot     : true when exactly one bit is set
package gray_pkg;

  localparam int unsigned GRAY_WIDTH_DEF = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b     = '0;
    b[31] = g[31];
    for (int unsigned i = 31; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

  function automatic logic is_one_hot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/binary_to_gray.sv
// binary_to_gray -- combinational WIDTH-bit binary to Gray encoder.
//   bin_i  : binary input
//   gray_o : Gray code of bin_i
module binary_to_gray
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = WIDTH'(bin2gray(32'(bin_i)));

endmodule

// File: rtl/gray_counter.sv
// gray_counter -- registered up/down Gray-code counter with parallel load.
// Priority per edge: rst > load > en > hold. gray_out is encoded from the
// next binary value and registered, so it never glitches.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset (count := INIT)
//   en       : step enable, one step per cycle
//   up_dn    : 1 = count up, 0 = count down
//   load     : synchronous load of load_bin
//   load_bin : binary value to load
//   gray_out : registered Gray code of the count
//   bin_out  : registered binary count
//   wrap     : one-cycle pulse when the wrapped value is presented
//   err      : sticky single-bit-change violation flag
// Optional macro GRAY_CNT_ERRCHK_EN enables the single-bit-change checker;
// without it err is tied low.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH_DEF,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);

  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             step;

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    step   = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      step = 1'b1;
      if (up_dn) begin
        bin_d  = bin_q + 1'b1;
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - 1'b1;
        wrap_d = ~|bin_q;
      end
    end
  end

  binary_to_gray #(
    .WIDTH(WIDTH)
  ) u_enc (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= INIT_BIN;
      gray_q <= INIT_GRAY;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;

`ifdef GRAY_CNT_ERRCHK_EN
  // gray_prev_q trails gray_q by one cycle; step_q marks that the last
  // update was an enabled step, so load/reset transitions are never checked.
  logic [WIDTH-1:0] gray_prev_q;
  logic             step_q;
  logic             err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (step_q && !is_one_hot(32'(gray_prev_q ^ gray_q))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_prev_q <= INIT_GRAY;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      gray_prev_q <= gray_q;
      step_q      <= step;
      err_q       <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_bin;
  logic [3:0] gray_out;
  logic [3:0] bin_out;
  logic       wrap;
  logic       err;

  gray_counter #(
    .WIDTH(4),
    .INIT (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_bin (load_bin),
    .gray_out (gray_out),
    .bin_out  (bin_out),
    .wrap     (wrap),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] bin;
    logic [3:0] gray;
    logic       wrap;
    logic       err;
  } obs_t;

  obs_t       sb_q[$];
  logic [3:0] m_bin;
  int         n_tests;
  int         n_fail;

  // Gray sequence for counting up from 0, written out independently.
  logic [3:0] up_tab [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                              4'b0111, 4'b0101, 4'b0100, 4'b1100,
                              4'b1101, 4'b1111, 4'b1110, 4'b1010,
                              4'b1011, 4'b1001, 4'b1000, 4'b0000};

  // Drive one cycle of controls, push the model's expected result, and
  // advance to just after the sampling edge.
  task automatic drive(input logic r, input logic l, input logic [3:0] lb,
                       input logic e, input logic u);
    obs_t x;
    rst = r; load = l; load_bin = lb; en = e; up_dn = u;
    x.wrap = 1'b0;
    x.err  = 1'b0;
    if (r) begin
      m_bin = 4'd0;
    end else if (l) begin
      m_bin = lb;
    end else if (e) begin
      if (u) begin
        x.wrap = (m_bin == 4'hF);
        m_bin  = m_bin + 4'd1;
      end else begin
        x.wrap = (m_bin == 4'h0);
        m_bin  = m_bin - 4'd1;
      end
    end
    x.bin  = m_bin;
    x.gray = m_bin ^ (m_bin >> 1);
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_reset();
    obs_t exp, got;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
      exp = sb_q.pop_front();
      got = {bin_out, gray_out, wrap, err};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset: got bin=%b gray=%b wrap=%b err=%b expected bin=%b gray=%b wrap=%b err=%b",
                 got.bin, got.gray, got.wrap, got.err, exp.bin, exp.gray, exp.wrap, exp.err);
      end
    end
  endtask

  task automatic test_count_up();
    obs_t exp, got;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
      exp = sb_q.pop_front();
      got = {bin_out, gray_out, wrap, err};
      n_tests++;
      if (got !== exp || gray_out !== up_tab[i] || wrap !== (i == 15)) begin
        n_fail++;
        $display("FAIL count_up[%0d]: got bin=%b gray=%b wrap=%b err=%b expected bin=%b gray=%b wrap=%b err=%b",
                 i, got.bin, got.gray, got.wrap, got.err, exp.bin, up_tab[i], exp.wrap, exp.err);
      end
    end
  endtask

  task automatic test_count_down();
    obs_t exp, got;
    logic [9:0] fixed [2] = '{{4'b1111, 4'b1000, 1'b1, 1'b0},
                              {4'b1110, 4'b1001, 1'b0, 1'b0}};
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      exp = sb_q.pop_front();
      got = {bin_out, gray_out, wrap, err};
      n_tests++;
      if (got !== exp || got !== fixed[i]) begin
        n_fail++;
        $display("FAIL count_down[%0d]: got bin=%b gray=%b wrap=%b expected bin=%b gray=%b wrap=%b",
                 i, got.bin, got.gray, got.wrap, exp.bin, exp.gray, exp.wrap);
      end
    end
  endtask

  task automatic test_load_priority();
    obs_t exp, got;
    drive(1'b0, 1'b1, 4'b1010, 1'b1, 1'b1);
    exp = sb_q.pop_front();
    got = {bin_out, gray_out, wrap, err};
    n_tests++;
    if (got !== exp || gray_out !== 4'b1111) begin
      n_fail++;
      $display("FAIL load_priority: got bin=%b gray=%b wrap=%b expected bin=%b gray=%b wrap=%b",
               got.bin, got.gray, got.wrap, exp.bin, exp.gray, exp.wrap);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 4'h3, 1'b0, 1'b1);
      exp = sb_q.pop_front();
      got = {bin_out, gray_out, wrap, err};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL load_hold[%0d]: got bin=%b gray=%b wrap=%b expected bin=%b gray=%b wrap=%b",
                 i, got.bin, got.gray, got.wrap, exp.bin, exp.gray, exp.wrap);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t exp, got;
    drive(1'b0, 1'b1, 4'b0101, 1'b0, 1'b1);
    void'(sb_q.pop_front());
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    exp = sb_q.pop_front();
    got = {bin_out, gray_out, wrap, err};
    n_tests++;
    if (got !== exp || bin_out !== 4'b0110) begin
      n_fail++;
      $display("FAIL pre_reset_step: got bin=%b gray=%b expected bin=%b gray=%b",
               got.bin, got.gray, exp.bin, exp.gray);
    end
    drive(1'b1, 1'b1, 4'hC, 1'b1, 1'b1);
    exp = sb_q.pop_front();
    got = {bin_out, gray_out, wrap, err};
    n_tests++;
    if (got !== exp || got !== 10'b0000_0000_0_0) begin
      n_fail++;
      $display("FAIL reset_mid: got bin=%b gray=%b wrap=%b err=%b expected bin=%b gray=%b wrap=%b err=%b",
               got.bin, got.gray, got.wrap, got.err, exp.bin, exp.gray, exp.wrap, exp.err);
    end
  endtask

  // Long mixed run: random direction/enable with occasional loads. Each
  // enabled step must move gray_out by exactly one bit, and err stays low.
  task automatic test_sweeps();
    obs_t       exp, got;
    logic [3:0] prev_g;
    logic [3:0] diff;
    logic       e, u, l;
    for (int i = 0; i < 120; i++) begin
      prev_g = gray_out;
      l = ($urandom_range(0, 15) == 0);
      e = (i < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
      u = (i < 20) ? 1'b1 : (i < 40) ? 1'b0 : 1'($urandom_range(0, 1));
      drive(1'b0, l, 4'($urandom_range(0, 15)), e, u);
      exp = sb_q.pop_front();
      got = {bin_out, gray_out, wrap, err};
      diff = prev_g ^ gray_out;
      n_tests++;
      if (got !== exp || (e && !l && $countones(diff) != 1)) begin
        n_fail++;
        $display("FAIL sweep[%0d]: got bin=%b gray=%b wrap=%b err=%b prev_gray=%b expected bin=%b gray=%b wrap=%b err=%b",
                 i, got.bin, got.gray, got.wrap, got.err, prev_g, exp.bin, exp.gray, exp.wrap, exp.err);
      end
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    m_bin    = 4'd0;
    rst      = 1'b0;
    en       = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_bin = 4'h0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load_priority();
    test_reset_mid();
    test_sweeps();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
